// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
//
// Instruction fetch unit with a DEPTH-entry prefetch queue. It issues
// sequential read requests to a synchronous instruction memory with a
// one-cycle read latency. It stores each returned word together with its PC,
// and presents the queue head to decode over a valid/ready handshake.
// A redirect pulse flushes the queue, squashes any read in flight and
// restarts fetch at the aligned redirect_pc.
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous, active-low; clears all state
//   fetch_en     in   1        permits new fetch requests
//   redirect     in   1        flush and restart at redirect_pc
//   redirect_pc  in   ADDR_W   restart PC (low alignment bits ignored)
//   in_mem_en    out  1        memory read request this cycle
//   in_mem_addr  out  ADDR_W   memory read address (the PC register)
//   in_mem       in   INSTR_W  read data, valid the cycle after in_mem_en
//   instr_valid  out  1        queue head valid
//   instr_ready  in   1        decode accepts the head
//   instr        out  INSTR_W  head instruction (0 when not valid)
//   instr_pc     out  ADDR_W   head instruction address (0 when not valid)
// ---------------------------------------------------------------------------
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               in_mem_en,
    output logic [ADDR_W-1:0]  in_mem_addr,
    input  logic [INSTR_W-1:0] in_mem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int STEP  = INSTR_W / 8;
    localparam int ALIGN = $clog2(STEP);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN) - ADDR_W'(1));
    localparam logic [CW:0]       DEPTH_OCC  = (CW + 1)'(DEPTH);

    // Architectural state
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Queue storage (not reset; qualified by count)
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];

    logic [CW:0] occ_s;
    logic        issue_s;
    logic        push_s;
    logic        pop_s;

    // Occupancy includes the read in flight so its landing slot is reserved;
    // the issue decision never looks at instr_ready, and reset holds it low.
    always_comb begin
        occ_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue_s = reset & fetch_en & ~redirect & (occ_s < DEPTH_OCC);
        push_s  = inflight_q & ~redirect;
        pop_s   = instr_valid & instr_ready;
    end

    // Next-state computation; redirect overrides every other update
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            pc_d     = redirect_pc & ALIGN_MASK;
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (issue_s) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + PC_STEP;
            end else begin
                inflight_d = 1'b0;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ADDR_W{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage write: returned word paired with the PC it was fetched from
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem[wr_ptr_q] <= in_mem;
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    // Output drive; head fields are forced to zero when the queue is empty
    always_comb begin
        in_mem_en   = issue_s;
        in_mem_addr = pc_q;
        instr_valid = (count_q != {CW{1'b0}});
        if (instr_valid) begin
            instr    = data_mem[rd_ptr_q];
            instr_pc = pc_mem[rd_ptr_q];
        end else begin
            instr    = {INSTR_W{1'b0}};
            instr_pc = {ADDR_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch
//
// Directed bench for if_prefetch. Two instances: u_dut (RESET_PC=0) is driven
// through sequential fetch, backpressure, redirects, fetch_en toggling and an
// asynchronous reset mid-stream; u_wrap (RESET_PC=FFFFFFF8) free-runs to show
// PC wrap. Each instance has a memory model returning word = address.
// ---------------------------------------------------------------------------
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        in_mem_en;
    logic [31:0] in_mem_addr;
    logic [31:0] in_mem = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_mem = 32'h0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    int vectors    = 0;
    int miscompares = 0;
    int issues      = 0;

    always #5 clk = ~clk;

    if_prefetch #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .in_mem_en(in_mem_en), .in_mem_addr(in_mem_addr),
        .in_mem(in_mem), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    if_prefetch #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .fetch_en(1'b1), .redirect(1'b0),
        .redirect_pc(32'h0), .in_mem_en(w_en), .in_mem_addr(w_addr),
        .in_mem(w_mem), .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_pc)
    );

    // Synchronous memories, one-cycle latency, word = address
    always @(posedge clk) begin
        if (in_mem_en) in_mem <= in_mem_addr;
        if (w_en)      w_mem  <= w_addr;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply reset for one cycle, release it just after a rising edge (cycle 0)
    task automatic do_reset(input logic fe, input logic rdy);
        step();
        reset = 1'b0;
        redirect = 1'b0;
        fetch_en = fe;
        instr_ready = rdy;
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;

        // ---- reset state (held in reset with fetch_en high) ----
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        step();
        #1;
        check_vec("rst_en", 32'(in_mem_en), 32'h0);
        check_vec("rst_addr", in_mem_addr, 32'h0);
        check_vec("rst_valid", 32'(instr_valid), 32'h0);
        check_vec("rst_instr", instr, 32'h0);
        check_vec("rst_pc", instr_pc, 32'h0);
        check_vec("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

        // ---- sequential fetch, ready high; wrap instance alongside ----
        do_reset(1'b1, 1'b1);
        check_vec("seq_en0", 32'(in_mem_en), 32'h1);
        check_vec("seq_addr0", in_mem_addr, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            #1;
            check_vec("seq_addr", in_mem_addr, 32'(4 * k));
            check_vec("seq_valid", 32'(instr_valid), (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                check_vec("seq_pc", instr_pc, 32'(4 * (k - 2)));
                check_vec("seq_instr", instr, 32'(4 * (k - 2)));
                exp_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
                check_vec("wrap_pc", w_pc, exp_pc);
                check_vec("wrap_instr", w_instr, exp_pc);
            end else begin
                check_vec("wrap_valid0", 32'(w_valid), 32'h0);
            end
        end

        // ---- backpressure: ready low for 10 cycles ----
        do_reset(1'b1, 1'b0);
        issues = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                step();
                #1;
            end
            if (in_mem_en) issues++;
            if (k == 4) check_vec("bp_en_fall", 32'(in_mem_en), 32'h0);
            if (k == 3) check_vec("bp_en_last", 32'(in_mem_en), 32'h1);
        end
        check_vec("bp_issues", 32'(issues), 32'd4);
        check_vec("bp_addr_hold", in_mem_addr, 32'h10);
        check_vec("bp_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        #1;
        check_vec("bp_en_c10", 32'(in_mem_en), 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                step();
                #1;
            end
            check_vec("bp_pop_pc", instr_pc, 32'(4 * k));
            check_vec("bp_pop_valid", 32'(instr_valid), 32'h1);
            if (k == 1) begin
                check_vec("bp_en_rise", 32'(in_mem_en), 32'h1);
                check_vec("bp_addr_rise", in_mem_addr, 32'h10);
            end
        end

        // ---- redirect with 3 queued and 1 in flight ----
        do_reset(1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) step();
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        check_vec("rd_no_issue", 32'(in_mem_en), 32'h0);
        check_vec("rd_pre_head", instr_pc, 32'h0);
        step();
        redirect = 1'b0;
        instr_ready = 1'b1;
        #1;
        check_vec("rd_valid_t1", 32'(instr_valid), 32'h0);
        check_vec("rd_addr_t1", in_mem_addr, 32'h100);
        check_vec("rd_en_t1", 32'(in_mem_en), 32'h1);
        step();
        #1;
        check_vec("rd_valid_t2", 32'(instr_valid), 32'h0);
        step();
        #1;
        check_vec("rd_valid_t3", 32'(instr_valid), 32'h1);
        check_vec("rd_pc_t3", instr_pc, 32'h100);
        check_vec("rd_instr_t3", instr, 32'h100);
        step();
        #1;
        check_vec("rd_pc_t4", instr_pc, 32'h104);

        // ---- redirect with pop, then fetch_en toggling ----
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) step();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check_vec("rp_head", instr_pc, 32'h8);
        step();
        redirect = 1'b0;
        #1;
        check_vec("rp_valid5", 32'(instr_valid), 32'h0);
        check_vec("rp_addr5", in_mem_addr, 32'h200);
        step();
        step();
        fetch_en = 1'b0;
        #1;
        check_vec("rp_pc7", instr_pc, 32'h200);
        check_vec("rp_en7", 32'(in_mem_en), 32'h0);
        step();
        #1;
        check_vec("rp_inflight_pc", instr_pc, 32'h204);
        check_vec("rp_inflight_v", 32'(instr_valid), 32'h1);
        check_vec("rp_en8", 32'(in_mem_en), 32'h0);
        step();
        fetch_en = 1'b1;
        #1;
        check_vec("rp_valid9", 32'(instr_valid), 32'h0);
        check_vec("rp_addr9", in_mem_addr, 32'h208);
        check_vec("rp_en9", 32'(in_mem_en), 32'h1);
        step();
        step();
        #1;
        check_vec("rp_pc11", instr_pc, 32'h208);

        // ---- asynchronous reset with count=3, inflight=1 ----
        do_reset(1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) step();
        check_vec("ar_pre_valid", 32'(instr_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_vec("ar_valid", 32'(instr_valid), 32'h0);
        check_vec("ar_instr", instr, 32'h0);
        check_vec("ar_pc", instr_pc, 32'h0);
        check_vec("ar_en", 32'(in_mem_en), 32'h0);
        check_vec("ar_addr", in_mem_addr, 32'h0);
        step();
        reset = 1'b1;
        instr_ready = 1'b1;
        #1;
        check_vec("ar_restart_en", 32'(in_mem_en), 32'h1);
        check_vec("ar_restart_addr", in_mem_addr, 32'h0);
        step();
        step();
        #1;
        check_vec("ar_first_pc", instr_pc, 32'h0);
        check_vec("ar_first_valid", 32'(instr_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
